// File: rtl/fpu_f16_to_int16.sv
// fp16 to signed integer converter, round-to-nearest-even.
// Multi-cycle: the significand moves one bit per cycle toward its integer position.
package fpu_f16_to_int16_pkg;
   typedef struct packed {
      logic       sign;
      logic [4:0] exp;
      logic [9:0] frac;
   } fp16_t;

   typedef struct packed {
      logic z;
      logic c;
      logic n;
      logic v;
   } condCode_t;

   typedef struct packed {
      logic invalid;
      logic div_zero;
      logic overflow;
      logic underflow;
      logic inexact;
   } opStatusFlag_t;
endpackage

module fpu_f16_to_int16
   import fpu_f16_to_int16_pkg::*;
#(
   parameter int INTW = 16
) (
   input  logic            clock,
   input  logic            reset_L,
   input  logic            inValid,
   output logic            inReady,
   input  fp16_t           fpuIn,
   output logic            outValid,
   input  logic            outReady,
   output logic [INTW-1:0] intOut,
   output condCode_t       condCodes,
   output opStatusFlag_t   opStatusFlags
);

   typedef enum logic [1:0] {IDLE, SHIFT, ROUND, DONE} state_t;

   localparam logic [INTW-1:0] MAX_POS = {1'b0, {(INTW-1){1'b1}}};
   localparam logic [INTW-1:0] MIN_NEG = {1'b1, {(INTW-1){1'b0}}};

   state_t          state_q, state_d;
   logic [INTW-1:0] mag_q, mag_d;
   logic            guard_q, guard_d;
   logic            sticky_q, sticky_d;
   logic [4:0]      cnt_q, cnt_d;
   logic            left_q, left_d;
   logic            sign_q, sign_d;
   logic [INTW-1:0] int_q, int_d;
   condCode_t       cc_q, cc_d;
   opStatusFlag_t   flags_q, flags_d;

   logic [31:0]     exp32;
   assign exp32 = {27'b0, fpuIn.exp};

   // Next-state, datapath shifting and result loading
   always_comb begin
      logic [INTW-1:0] res;
      logic [INTW-1:0] rnd;
      logic            inv;
      logic            inx;
      logic            load;
      logic            inc;
      logic [4:0]      n;
      state_d  = state_q;
      mag_d    = mag_q;
      guard_d  = guard_q;
      sticky_d = sticky_q;
      cnt_d    = cnt_q;
      left_d   = left_q;
      sign_d   = sign_q;
      int_d    = int_q;
      cc_d     = cc_q;
      flags_d  = flags_q;
      res      = '0;
      rnd      = '0;
      inv      = 1'b0;
      inx      = 1'b0;
      load     = 1'b0;
      inc      = 1'b0;
      n        = '0;
      unique case (state_q)
         IDLE: begin
            if (inValid) begin
               sign_d   = fpuIn.sign;
               guard_d  = 1'b0;
               sticky_d = 1'b0;
               if (fpuIn.exp == 5'd31) begin
                  load    = 1'b1;
                  inv     = 1'b1;
                  res     = (fpuIn.frac != '0 || !fpuIn.sign)
                          ? MAX_POS : MIN_NEG;
                  state_d = DONE;
               end else if (exp32 >= 32'(INTW + 14)) begin
                  load    = 1'b1;
                  res     = fpuIn.sign ? MIN_NEG : MAX_POS;
                  inv     = !(fpuIn.sign && fpuIn.frac == '0 &&
                              exp32 == 32'(INTW + 14));
                  state_d = DONE;
               end else if (fpuIn.exp < 5'd14) begin
                  load    = 1'b1;
                  res     = '0;
                  inx     = (fpuIn.exp != '0) || (fpuIn.frac != '0);
                  state_d = DONE;
               end else begin
                  mag_d   = INTW'({1'b1, fpuIn.frac});
                  left_d  = fpuIn.exp > 5'd25;
                  n       = left_d ? fpuIn.exp - 5'd25
                                   : 5'd25 - fpuIn.exp;
                  cnt_d   = n;
                  state_d = (n == '0) ? ROUND : SHIFT;
               end
            end
         end
         SHIFT: begin
            if (left_q) begin
               mag_d = mag_q << 1;
            end else begin
               mag_d    = mag_q >> 1;
               guard_d  = mag_q[0];
               sticky_d = sticky_q | guard_q;
            end
            cnt_d = cnt_q - 5'd1;
            if (cnt_q == 5'd1) state_d = ROUND;
         end
         ROUND: begin
            inc     = guard_q & (sticky_q | mag_q[0]);
            rnd     = mag_q + INTW'(inc);
            res     = sign_q ? (~rnd + 1'b1) : rnd;
            inx     = guard_q | sticky_q;
            load    = 1'b1;
            state_d = DONE;
         end
         DONE: begin
            if (outReady) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (load) begin
         int_d   = res;
         cc_d    = '{z: (res == '0), c: 1'b0,
                     n: res[INTW-1], v: 1'b0};
         flags_d = '{invalid: inv, inexact: inx, default: 1'b0};
      end
   end

   // State and datapath registers, cleared asynchronously
   always_ff @(posedge clock or negedge reset_L) begin
      if (!reset_L) begin
         state_q  <= IDLE;
         mag_q    <= '0;
         guard_q  <= 1'b0;
         sticky_q <= 1'b0;
         cnt_q    <= '0;
         left_q   <= 1'b0;
         sign_q   <= 1'b0;
         int_q    <= '0;
         cc_q     <= '0;
         flags_q  <= '0;
      end else begin
         state_q  <= state_d;
         mag_q    <= mag_d;
         guard_q  <= guard_d;
         sticky_q <= sticky_d;
         cnt_q    <= cnt_d;
         left_q   <= left_d;
         sign_q   <= sign_d;
         int_q    <= int_d;
         cc_q     <= cc_d;
         flags_q  <= flags_d;
      end
   end

   assign inReady       = (state_q == IDLE);
   assign outValid      = (state_q == DONE);
   assign intOut        = int_q;
   assign condCodes     = cc_q;
   assign opStatusFlags = flags_q;

endmodule

// File: tb/tb_fpu_f16_to_int16.sv
// Directed-vector bench for fpu_f16_to_int16 (INTW=16).
// Checks value, codes, flags and latency, plus backpressure and reset.
module tb_fpu_f16_to_int16;
   import fpu_f16_to_int16_pkg::*;

   typedef struct {
      logic [15:0] in;
      logic [15:0] res;
      logic [3:0]  cc;
      logic [4:0]  fl;
      int          lat;
   } vec_t;

   localparam logic [4:0] INV = 5'b10000;
   localparam logic [4:0] INX = 5'b00001;
   localparam logic [3:0] CZ  = 4'b1000;
   localparam logic [3:0] CN  = 4'b0010;

   logic          clock = 1'b0;
   logic          reset_L = 1'b0;
   logic          inValid = 1'b0;
   logic          outReady = 1'b1;
   logic [15:0]   fpuIn = '0;
   logic          inReady;
   logic          outValid;
   logic [15:0]   intOut;
   condCode_t     condCodes;
   opStatusFlag_t opStatusFlags;

   int errors = 0;
   int checks = 0;

   fpu_f16_to_int16 #(.INTW(16)) dut (
      .clock         (clock),
      .reset_L       (reset_L),
      .inValid       (inValid),
      .inReady       (inReady),
      .fpuIn         (fpuIn),
      .outValid      (outValid),
      .outReady      (outReady),
      .intOut        (intOut),
      .condCodes     (condCodes),
      .opStatusFlags (opStatusFlags)
   );

   always #5 clock = ~clock;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h required %0h", nm, act, req);
      end
   endtask

   task automatic run(input logic [15:0] v, output int lat,
                      output logic ok);
      @(negedge clock);
      fpuIn   = v;
      inValid = 1'b1;
      lat     = 0;
      ok      = 1'b0;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clock);
         #1;
         inValid = 1'b0;
         if (outValid) begin
            lat = k;
            ok  = 1'b1;
            break;
         end
      end
   endtask

   vec_t vecs[23];

   initial begin
      int   lat;
      logic ok;
      logic seen;

      vecs[0]  = '{16'h4500, 16'h0005, 4'b0000, 5'b0, 10};
      vecs[1]  = '{16'hC900, 16'hFFF6, CN,      5'b0, 9};
      vecs[2]  = '{16'h3800, 16'h0000, CZ,      INX,  13};
      vecs[3]  = '{16'h3E00, 16'h0002, 4'b0000, INX,  12};
      vecs[4]  = '{16'h4100, 16'h0002, 4'b0000, INX,  11};
      vecs[5]  = '{16'h3C00, 16'h0001, 4'b0000, 5'b0, 12};
      vecs[6]  = '{16'hB666, 16'h0000, CZ,      INX,  1};
      vecs[7]  = '{16'hF800, 16'h8000, CN,      5'b0, 1};
      vecs[8]  = '{16'h7800, 16'h7FFF, 4'b0000, INV,  1};
      vecs[9]  = '{16'h7C00, 16'h7FFF, 4'b0000, INV,  1};
      vecs[10] = '{16'hFC00, 16'h8000, CN,      INV,  1};
      vecs[11] = '{16'h7E00, 16'h7FFF, 4'b0000, INV,  1};
      vecs[12] = '{16'h0001, 16'h0000, CZ,      INX,  1};
      vecs[13] = '{16'h0000, 16'h0000, CZ,      5'b0, 1};
      vecs[14] = '{16'h7000, 16'h2000, 4'b0000, 5'b0, 5};
      vecs[15] = '{16'h77FF, 16'h7FF0, 4'b0000, 5'b0, 6};
      vecs[16] = '{16'hBE00, 16'hFFFE, CN,      INX,  12};
      vecs[17] = '{16'h4180, 16'h0003, 4'b0000, INX,  11};
      vecs[18] = '{16'hFBFF, 16'h8000, CN,      INV,  1};
      vecs[19] = '{16'h6400, 16'h0400, 4'b0000, 5'b0, 2};
      vecs[20] = '{16'hB800, 16'h0000, CZ,      INX,  13};
      vecs[21] = '{16'hFE00, 16'h7FFF, 4'b0000, INV,  1};
      vecs[22] = '{16'h0400, 16'h0000, CZ,      INX,  1};

      #12;
      chk("rst outValid", 32'(outValid), 0);
      chk("rst inReady", 32'(inReady), 1);
      chk("rst intOut", 32'(intOut), 0);
      chk("rst condCodes", 32'(condCodes), 0);
      chk("rst flags", 32'(opStatusFlags), 0);
      repeat (2) @(negedge clock);
      reset_L = 1'b1;

      foreach (vecs[i]) begin
         run(vecs[i].in, lat, ok);
         chk($sformatf("v%0d %h done", i, vecs[i].in), 32'(ok), 1);
         chk($sformatf("v%0d %h lat", i, vecs[i].in), lat, vecs[i].lat);
         chk($sformatf("v%0d %h int", i, vecs[i].in),
             32'(intOut), 32'(vecs[i].res));
         chk($sformatf("v%0d %h cc", i, vecs[i].in),
             32'(condCodes), 32'(vecs[i].cc));
         chk($sformatf("v%0d %h flags", i, vecs[i].in),
             32'(opStatusFlags), 32'(vecs[i].fl));
         @(posedge clock);
         #1;
         chk($sformatf("v%0d idle", i), 32'(inReady), 1);
      end

      outReady = 1'b0;
      run(16'h6400, lat, ok);
      chk("bp done", 32'(ok), 1);
      chk("bp lat", lat, 2);
      for (int c = 0; c < 5; c++) begin
         @(negedge clock);
         inValid = 1'b1;
         fpuIn   = 16'h3C00;
         @(posedge clock);
         #1;
         chk($sformatf("bp%0d outValid", c), 32'(outValid), 1);
         chk($sformatf("bp%0d int", c), 32'(intOut), 32'h0400);
         chk($sformatf("bp%0d inReady", c), 32'(inReady), 0);
      end
      @(negedge clock);
      inValid  = 1'b0;
      outReady = 1'b1;
      @(posedge clock);
      #1;
      chk("bp release outValid", 32'(outValid), 0);
      chk("bp release inReady", 32'(inReady), 1);
      chk("bp release int hold", 32'(intOut), 32'h0400);
      repeat (3) @(posedge clock);
      #1;
      chk("bp ignored pulses", 32'(inReady), 1);

      @(negedge clock);
      fpuIn   = 16'h4500;
      inValid = 1'b1;
      @(posedge clock);
      #1;
      inValid = 1'b0;
      chk("mid accepted", 32'(inReady), 0);
      repeat (3) @(posedge clock);
      #1;
      reset_L = 1'b0;
      #1;
      chk("mid rst outValid", 32'(outValid), 0);
      chk("mid rst inReady", 32'(inReady), 1);
      chk("mid rst intOut", 32'(intOut), 0);
      chk("mid rst flags", 32'(opStatusFlags), 0);
      repeat (2) @(negedge clock);
      reset_L = 1'b1;
      seen = 1'b0;
      repeat (20) begin
         @(posedge clock);
         #1;
         if (outValid) seen = 1'b1;
      end
      chk("no result after reset", 32'(seen), 0);
      run(16'h3C00, lat, ok);
      chk("post rst done", 32'(ok), 1);
      chk("post rst lat", lat, 12);
      chk("post rst int", 32'(intOut), 1);
      chk("post rst flags", 32'(opStatusFlags), 0);
      @(posedge clock);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
